// File: rtl/fir_output_stage_if.sv
// Output-side handshake bundle of fir_output_stage: FIFO head sample, valid/ready
// pair and FIFO status. The master side is the output stage; the slave side is the sink.
interface fir_output_stage_if #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic signed [OUT_W-1:0] y_out;
    logic                    y_valid;
    logic                    y_ready;
    logic                    full;
    logic [LW-1:0]           level;
    logic                    drop;

    modport master (
        output y_out,
        output y_valid,
        output full,
        output level,
        output drop,
        input  y_ready
    );

    modport slave (
        input  y_out,
        input  y_valid,
        input  full,
        input  level,
        input  drop,
        output y_ready
    );
endinterface

// File: rtl/fir_output_stage.sv
// FIR output stage: registers the accumulated tap sum on each sample strobe, rounds
// (ties toward +inf) and arithmetic-shifts it, saturates to OUT_W bits and buffers the
// result in a first-word-fall-through FIFO feeding a valid/ready sink. Overflow never
// stalls the filter; a sample arriving at a full FIFO with no pop is dropped.
// Optional: define FIR_OUT_SAT_CNT_EN to add the sticky 16-bit saturation counter sat_cnt.
module fir_output_stage #(
    parameter int N     = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N-1:0]         y_in,
`ifdef FIR_OUT_SAT_CNT_EN
    output logic [15:0]          sat_cnt,
`endif
    fir_output_stage_if.master   out_if
);
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int RndPos = (SHIFT == 0) ? 0 : SHIFT - 1;

    // Rounding constant 2^(SHIFT-1); no rounding at all when SHIFT is 0.
    localparam logic signed [N:0] RndAdd = (SHIFT == 0) ? '0 : ((N+1)'(1) << RndPos);
    // Output range limits expressed in the N+1 bit rounding domain.
    localparam logic signed [N:0] SatMax = {{(N+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [N:0] SatMin = {{(N+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [N-1:0]            r_s1;
    logic                    r_s1_v;
    logic signed [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_level;

    logic signed [N:0]       w_ext;
    logic signed [N:0]       w_sum;
    logic signed [N:0]       w_r;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic signed [OUT_W-1:0] w_sat;
    logic                    w_full;
    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // Stage 1: capture the tap sum on its strobe; the valid flag follows ena each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= '0;
            r_s1_v <= 1'b0;
        end else begin
            if (ena) begin
                r_s1 <= y_in;
            end
            r_s1_v <= ena;
        end
    end

    // Stage 2: round, shift and saturate; one extra bit keeps the rounding add exact.
    always_comb begin
        w_ext    = {r_s1[N-1], r_s1};
        w_sum    = w_ext + RndAdd;
        w_r      = w_sum >>> SHIFT;
        w_sat_hi = (w_r > SatMax);
        w_sat_lo = (w_r < SatMin);
        if (w_sat_hi) begin
            w_sat = SatMax[OUT_W-1:0];
        end else if (w_sat_lo) begin
            w_sat = SatMin[OUT_W-1:0];
        end else begin
            w_sat = w_r[OUT_W-1:0];
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so push+pop when full is legal.
    always_comb begin
        w_full  = (r_level == LW'(DEPTH));
        w_valid = (r_level != '0);
        w_pop   = w_valid & out_if.y_ready;
        w_push  = r_s1_v & (~w_full | w_pop);
        w_drop  = r_s1_v & w_full & ~w_pop;
    end

    // FIFO storage; contents need no reset because y_out is gated by valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sat;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef FIR_OUT_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    // Sticky count of clipped samples offered to the FIFO, dropped ones included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_cnt <= '0;
        end else if (r_s1_v && (w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

    assign out_if.y_out   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign out_if.y_valid = w_valid;
    assign out_if.full    = w_full;
    assign out_if.level   = r_level;
    assign out_if.drop    = w_drop;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage: table of rounding/saturation vectors plus
// hand-written sequences for fill/overflow, push+pop while full, mid-stream reset
// and back-to-back streaming.
module tb_fir_output_stage;
    localparam int N     = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [N-1:0]  y_in;
`ifdef FIR_OUT_SAT_CNT_EN
    logic [15:0]   sat_cnt;
`endif

    fir_output_stage_if #(.OUT_W(OUT_W), .DEPTH(DEPTH)) out_if ();

    fir_output_stage #(
        .N     (N),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .y_in    (y_in),
`ifdef FIR_OUT_SAT_CNT_EN
        .sat_cnt (sat_cnt),
`endif
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] yin;
        int           exp;
        bit           sat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int yout();
        return int'(out_if.y_out);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sat_total;
        int outs;
        int exp_q [$];

        vecs[0]  = '{32'd32768,       1,      1'b0};
        vecs[1]  = '{32'd16384,       1,      1'b0};
        vecs[2]  = '{-32'sd16384,     0,      1'b0};
        vecs[3]  = '{-32'sd49152,     -1,     1'b0};
        vecs[4]  = '{32'h4000_0000,   32767,  1'b1};
        vecs[5]  = '{32'h8000_0000,   -32768, 1'b1};
        vecs[6]  = '{32'd0,           0,      1'b0};
        vecs[7]  = '{-32'sd16385,     -1,     1'b0};
        vecs[8]  = '{32'd49151,       1,      1'b0};
        vecs[9]  = '{32'd49152,       2,      1'b0};
        vecs[10] = '{32'h3FFF_8000,   32767,  1'b0};
        vecs[11] = '{32'h3FFF_C000,   32767,  1'b1};
        vecs[12] = '{32'hC000_0000,   -32768, 1'b0};
        vecs[13] = '{32'hBFFF_BFFF,   -32768, 1'b1};
        vecs[14] = '{32'h7FFF_FFFF,   32767,  1'b1};

        rst            = 1'b0;
        ena            = 1'b0;
        y_in           = '0;
        out_if.y_ready = 1'b0;
        #1;
        chk("reset_valid", out_if.y_valid, 0);
        chk("reset_level", out_if.level, 0);
        chk("reset_full", out_if.full, 0);
        chk("reset_drop", out_if.drop, 0);
        chk("reset_yout", yout(), 0);
        #22;
        rst = 1'b1;
        step();

        // Rounding and saturation table, one sample at a time.
        out_if.y_ready = 1'b1;
        sat_total = 0;
        for (int i = 0; i < 15; i++) begin
            y_in = vecs[i].yin;
            ena  = 1'b1;
            step();
            chk($sformatf("vec%0d_latency", i), out_if.y_valid, 0);
            ena = 1'b0;
            step();
            chk($sformatf("vec%0d_valid", i), out_if.y_valid, 1);
            chk($sformatf("vec%0d_yout", i), yout(), vecs[i].exp);
            chk($sformatf("vec%0d_level", i), out_if.level, 1);
            step();
            chk($sformatf("vec%0d_empty", i), out_if.y_valid, 0);
            if (vecs[i].sat) sat_total++;
`ifdef FIR_OUT_SAT_CNT_EN
            if (i == 5) chk("sat_cnt_after_pair", sat_cnt, 2);
`endif
        end
`ifdef FIR_OUT_SAT_CNT_EN
        chk("sat_cnt_table", sat_cnt, sat_total);
`endif

        // Fill and overflow with the sink stalled.
        out_if.y_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            y_in = N'(k * 32768);
            ena  = 1'b1;
            step();
            chk($sformatf("fill%0d_drop", k), out_if.drop, (k == 5) ? 1 : 0);
            if (k == 4) chk("fill4_level", out_if.level, 3);
            if (k == 5) begin
                chk("fill5_level", out_if.level, 4);
                chk("fill5_full", out_if.full, 1);
            end
        end
        ena = 1'b0;
        step();
        chk("ovf_drop_done", out_if.drop, 0);
        chk("ovf_level", out_if.level, 4);
        chk("ovf_head", yout(), 1);
        out_if.y_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("drain%0d_valid", j), out_if.y_valid, 1);
            chk($sformatf("drain%0d_yout", j), yout(), j);
            step();
        end
        chk("drain_empty", out_if.y_valid, 0);
        chk("drain_level", out_if.level, 0);
        chk("drain_full", out_if.full, 0);

        // Simultaneous push and pop while full.
        out_if.y_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            y_in = N'(k * 32768);
            ena  = 1'b1;
            step();
        end
        ena = 1'b0;
        step();
        chk("pp_full_level", out_if.level, 4);
        y_in = N'(14 * 32768);
        ena  = 1'b1;
        step();
        out_if.y_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c < 2) begin
                y_in = N'((15 + c) * 32768);
                ena  = 1'b1;
            end else begin
                ena = 1'b0;
            end
            #1;
            chk($sformatf("pp%0d_yout", c), yout(), 10 + c);
            chk($sformatf("pp%0d_level", c), out_if.level, 4);
            chk($sformatf("pp%0d_drop", c), out_if.drop, 0);
            step();
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("pp_tail%0d_yout", c), yout(), 14 + c);
            chk($sformatf("pp_tail%0d_level", c), out_if.level, 3 - c);
            step();
        end
        chk("pp_empty", out_if.y_valid, 0);

        // Asynchronous reset with three buffered samples and one in flight.
        out_if.y_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            y_in = N'(k * 32768);
            ena  = 1'b1;
            step();
        end
        ena = 1'b0;
        chk("rst_pre_level", out_if.level, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_valid", out_if.y_valid, 0);
        chk("rst_async_level", out_if.level, 0);
        chk("rst_async_full", out_if.full, 0);
`ifdef FIR_OUT_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 0);
`endif
        #2;
        rst = 1'b1;
        out_if.y_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rst_post%0d_valid", c), out_if.y_valid, 0);
            chk($sformatf("rst_post%0d_level", c), out_if.level, 0);
        end
        y_in = N'(7 * 32768);
        ena  = 1'b1;
        step();
        ena = 1'b0;
        step();
        chk("rst_new_valid", out_if.y_valid, 1);
        chk("rst_new_yout", yout(), 7);
        step();

        // Back-to-back streaming with the sink always ready.
        outs = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                y_in = N'((i + 1) * 32768);
                ena  = 1'b1;
                exp_q.push_back(i + 1);
            end else begin
                ena = 1'b0;
            end
            step();
            if (out_if.y_valid) begin
                if (exp_q.size() > 0) begin
                    chk($sformatf("b2b%0d_yout", outs), yout(), exp_q.pop_front());
                end else begin
                    chk("b2b_extra_output", 1, 0);
                end
                outs++;
            end
            chk($sformatf("b2b%0d_level_le1", i), (out_if.level <= 1) ? 1 : 0, 1);
            chk($sformatf("b2b%0d_drop", i), out_if.drop, 0);
        end
        chk("b2b_count", outs, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
- Downstream consumer of the last tapped delay block's accumulated y_out in the FIR chain.
- Registers the full-width sum on each sample strobe, then rounds and right-shifts it.
- Saturates the result to the output width and buffers it in a small FIFO.
- Presents results on a valid/ready interface to the sink (DAC driver or capture logic).

Parameters:
- N, 32, width of the signed accumulated input y_in.
- OUT_W, 16, width of the signed output sample; OUT_W <= N.
- SHIFT, 15, arithmetic right shift (coefficient fraction bits); 0 <= SHIFT < N.
- DEPTH, 4, FIFO depth in samples; power of 2, >= 2.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-low reset.
- ena, input, 1: y_in holds a valid filter sum this cycle (one-cycle strobe per sample).
- y_in, input, N: signed accumulated sum from the last tap.
- y_out, output, OUT_W: signed FIFO head sample.
- y_valid, output, 1: y_out holds a valid sample.
- y_ready, input, 1: sink accepts y_out this cycle.
- full, output, 1: FIFO holds DEPTH samples.
- level, output, $clog2(DEPTH)+1: number of samples in the FIFO.
- drop, output, 1: one-cycle pulse when a sample is discarded because the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous): capture register, valid flag, FIFO pointers and level clear to 0. Outputs y_out=0, y_valid=0, full=0, level=0, drop=0. Reset mid-stream discards all buffered and in-flight samples; no partial output follows release.
- Stage 1: on a posedge with ena=1, y_in is captured into s1 and s1_v is set to 1. With ena=0, s1_v is set to 0.
- Stage 2 rounding is combinational on s1, computed in N+1 bits so nothing overflows:
  - r = (s1 + 2^(SHIFT-1)) >>> SHIFT; the add is omitted when SHIFT=0.
  - Ties round toward +infinity.
- Saturation:
  - r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1.
  - r < -2^(OUT_W-1) gives -2^(OUT_W-1).
  - Otherwise the result is r truncated to OUT_W bits.
- Push: when s1_v=1, the saturated value is written into the FIFO at the next posedge.
- Latency: ena at edge t into an empty FIFO gives y_valid=1 and the correct y_out immediately after edge t+2.
- FIFO: first-word-fall-through. y_out is always the head entry; y_valid = (level != 0).
- Pop: occurs on a posedge with y_valid=1 and y_ready=1. y_ready is ignored while y_valid=0.
- Push and pop in the same cycle: both happen and level is unchanged. This applies when full as well; no drop in that case.
- Push while full with no pop: the sample is discarded, drop pulses for exactly one cycle, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. full = (level == DEPTH).
- Order is strictly preserved: no reordering or duplication.
- The handshake must not stall the FIR chain. Overflow is handled only by drop; there is no backpressure to the taps.

Optional Feature:
- Macro: FIR_OUT_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt, 16 bits.
  - Increments once per pushed sample that was clipped by saturation, including samples later dropped.
  - Holds at 0xFFFF (no wrap).
  - Clears only on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Rounding (SHIFT=15, OUT_W=16, y_ready=1), one ena pulse each:
  - y_in=32768 gives y_out=1.
  - y_in=16384 gives y_out=1 (tie rounds up).
  - y_in=-16384 gives y_out=0.
  - y_in=-49152 gives y_out=-1.
  - Each appears 2 cycles after its ena.
- Saturation:
  - y_in=0x40000000 gives y_out=32767.
  - y_in=0x80000000 gives y_out=-32768.
  - With FIR_OUT_SAT_CNT_EN defined, sat_cnt=2 afterwards.
- Fill/overflow (y_ready=0): 5 ena pulses with y_in=k*32768, k=1..5. Required result:
  - level=4 and full=1 after the 4th push.
  - drop pulses once for the 5th sample.
  - Then y_ready=1 drains 1,2,3,4 in order, with y_valid falling after the 4th.
- Simultaneous push/pop while full: level=4, ena and y_ready both high for 3 cycles. Required result:
  - level stays 4 and drop stays 0.
  - The outputs are the oldest samples in order.
- Reset mid-operation: level=3 and an ena in flight, then assert rst=0 asynchronously between edges. Required result:
  - y_valid=0, level=0, full=0 immediately.
  - No sample emerges after release until a new ena.
- Back-to-back streaming: ena every cycle for 20 cycles with y_ready=1. Required result:
  - One output per cycle, in order.
  - level never exceeds 1 and drop stays 0.
